// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and address check for the two-port memory arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef logic port_t;
  function automatic logic addr_err(input logic [31:0] adr, input int unsigned words);
    return (adr[1:0] != 2'b00) || ({2'b00, adr[31:2]} >= words);
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between the two request ports
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last,
  input  logic       force1,
  output port_t      win
);
  // a lone requester wins outright; a tie goes to the port not granted last, or to port 1 when forced
  always_comb win = (req == 2'b10) ? 1'b1 : (req == 2'b11) ? (force1 | ~last) : 1'b0;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter onto a unified word memory with alignment/range checking
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 64,
  parameter int          FIXED_PRI  = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  state_t state;
  logic lat_we, lat_err, force1, sel_we, err;
  port_t lat_port, last, last_in, win;
  logic [SW-1:0] starve;
  logic [1:0] req;
  logic [31:0] sel_adr, sel_wdata;
  assign req = {m1_req, m0_req};
  assign force1 = (FIXED_PRI != 0) && (starve == SMAX);
  assign last_in = (FIXED_PRI != 0) ? 1'b1 : last;
  arb_pick u_pick (.req(req), .last(last_in), .force1(force1), .win(win));
  // route the winning port's request and classify it
  always_comb begin
    sel_we = win ? m1_we : m0_we;
    sel_adr = win ? m1_adr : m0_adr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    err = addr_err(sel_adr, MEM_WORDS);
  end
  // two-state access FSM: latch the winner in IDLE, drive memory and capture read data in ACCESS
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      lat_we <= 1'b0;
      lat_err <= 1'b0;
      lat_port <= 1'b0;
      last <= 1'b0;
      starve <= '0;
      mem_we <= 1'b0;
      mem_adr <= '0;
      mem_wdata <= '0;
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state <= ACCESS;
          lat_we <= sel_we;
          lat_err <= err;
          lat_port <= win;
          last <= win;
          mem_we <= sel_we & ~err;
          mem_adr <= sel_adr;
          mem_wdata <= sel_wdata;
          m0_gnt <= ~win;
          m1_gnt <= win;
          m0_err <= ~win & err;
          m1_err <= win & err;
          if (FIXED_PRI != 0)
            starve <= win ? '0 : (req == 2'b11 && starve != SMAX) ? starve + 1'b1 : starve;
        end
      end else begin
        state <= IDLE;
        mem_we <= 1'b0;
        mem_adr <= '0;
        mem_wdata <= '0;
        m0_gnt <= 1'b0;
        m1_gnt <= 1'b0;
        m0_err <= 1'b0;
        m1_err <= 1'b0;
        if (!lat_we && !lat_err) begin
          if (lat_port) begin
            m1_rdata <= mem_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata <= mem_rdata;
            m0_rvalid <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for a round-robin and a fixed-priority mem_arb
module tb_mem_arb;
  typedef struct {
    int cyc;
    int inst;
    int port;
    int kind;
    logic [31:0] data;
  } ev_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic req[2][2], we[2][2];
  logic [31:0] adr[2][2], wdata[2][2];
  logic gnt[2][2], err[2][2], rvalid[2][2];
  logic [31:0] rdata[2][2];
  logic mem_we[2];
  logic [31:0] mem_adr[2], mem_wdata[2], mem_rdata[2];
  logic [31:0] ram[2][64];
  logic init_done = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : inst
    mem_arb #(.FIXED_PRI(g), .STARVE_MAX(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(req[g][0]), .m1_req(req[g][1]),
      .m0_we(we[g][0]), .m1_we(we[g][1]),
      .m0_adr(adr[g][0]), .m1_adr(adr[g][1]),
      .m0_wdata(wdata[g][0]), .m1_wdata(wdata[g][1]),
      .m0_gnt(gnt[g][0]), .m1_gnt(gnt[g][1]),
      .m0_rvalid(rvalid[g][0]), .m1_rvalid(rvalid[g][1]),
      .m0_rdata(rdata[g][0]), .m1_rdata(rdata[g][1]),
      .m0_err(err[g][0]), .m1_err(err[g][1]),
      .mem_we(mem_we[g]), .mem_adr(mem_adr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
    assign mem_rdata[g] = ram[g][mem_adr[g][7:2]];
  end

  // memory model: word i starts as 0x1000_0000 + i, written on the clock when mem_we is high
  always @(posedge clk)
    if (!init_done) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 64; j++) ram[i][j] <= 32'h1000_0000 + 32'(j);
      init_done <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (mem_we[i]) ram[i][mem_adr[i][7:2]] <= mem_wdata[i];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs(input int i);
    return rdata[i][0] | rdata[i][1] | mem_adr[i] | mem_wdata[i] |
           {28'b0, gnt[i][0] | gnt[i][1], err[i][0] | err[i][1], rvalid[i][0] | rvalid[i][1], mem_we[i]};
  endfunction

  // monitor: every gnt/rvalid pulse must match the next expected event, cycle included
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        if (err[i][p] && !gnt[i][p]) chk("err_without_gnt", 32'd1, 32'd0);
        if (gnt[i][p] && err[i][p]) chk("err_mem_we", {31'b0, mem_we[i]}, 32'd0);
        if (gnt[i][p] || rvalid[i][p]) begin
          int k;
          k = rvalid[i][p] ? 2 : err[i][p] ? 1 : 0;
          if (exp_q.size() == 0) chk("unexpected_event", {4'(i), 4'(p), 4'(k), 20'(cyc)}, 32'd0);
          else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("event", {4'(i), 4'(p), 4'(k), 20'(cyc)}, {4'(e.inst), 4'(e.port), 4'(e.kind), 20'(e.cyc)});
            if (k == 2) chk("rdata", rdata[i][p], e.data);
          end
        end
      end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic e, input logic [31:0] rd);
    req[i][p] = 1'b1;
    we[i][p] = w;
    adr[i][p] = a;
    wdata[i][p] = d;
    exp_q.push_back('{cyc + 1, i, p, e ? 1 : 0, 32'h0});
    if (!w && !e) exp_q.push_back('{cyc + 2, i, p, 2, rd});
    step(1);
    req[i][p] = 1'b0;
    step(2);
  endtask

  task automatic tie(input int i, input int last_cyc, input int pat[]);
    int c;
    c = cyc;
    req[i][0] = 1'b1; we[i][0] = 1'b1; adr[i][0] = 32'h40; wdata[i][0] = 32'hAAAA_0000;
    req[i][1] = 1'b1; we[i][1] = 1'b1; adr[i][1] = 32'h44; wdata[i][1] = 32'hBBBB_1111;
    foreach (pat[n]) exp_q.push_back('{c + 1 + 2 * n, i, pat[n], 0, 32'h0});
    step(last_cyc);
    req[i][0] = 1'b0;
    req[i][1] = 1'b0;
    step(2);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; adr[i][p] = '0; wdata[i][p] = '0;
      end
    reset_n = 1'b0;
    step(1);
    chk("reset_outs0", outs(0), 32'h0);
    chk("reset_outs1", outs(1), 32'h0);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("idle_outs0", outs(0), 32'h0);
    // single read of 0x10 returns word 4, and rdata then holds
    issue(0, 0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1000_0004);
    chk("rdata_hold", rdata[0][0], 32'h1000_0004);
    // m0 writes 5 to 0x20, m1 reads it back; m0 rdata is untouched by m1's read
    issue(0, 0, 1'b1, 32'h20, 32'h5, 1'b0, 32'h0);
    issue(0, 1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h5);
    chk("m0_rdata_kept", rdata[0][0], 32'h1000_0004);
    // round-robin tie after a port-1 grant: 0,1,0,1 two cycles apart
    tie(0, 7, '{0, 1, 0, 1});
    chk("tie_wr0", ram[0][16], 32'hAAAA_0000);
    chk("tie_wr1", ram[0][17], 32'hBBBB_1111);
    // misaligned and out-of-range writes, and a misaligned read: err, no write, no rvalid
    issue(0, 1, 1'b1, 32'h102, 32'hDEAD_BEEF, 1'b1, 32'h0);
    issue(0, 1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0);
    issue(0, 0, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0);
    chk("err_no_write", ram[0][0], 32'h1000_0000);
    // fixed priority with starvation guard: four port-0 wins, one port-1, then again
    tie(1, 19, '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
    // a request pulse that drops before any clock edge is never granted
    req[0][0] = 1'b1; we[0][0] = 1'b1; adr[0][0] = 32'h34; wdata[0][0] = 32'h77;
    #3;
    req[0][0] = 1'b0;
    step(3);
    chk("glitch_no_write", ram[0][13], 32'h1000_000D);
    // reset asserted during a write's ACCESS cycle cancels it
    req[0][0] = 1'b1; we[0][0] = 1'b1; adr[0][0] = 32'h30; wdata[0][0] = 32'h0000_0BAD;
    step(1);
    chk("we_before_reset", {31'b0, mem_we[0]}, 32'd1);
    reset_n = 1'b0;
    req[0][0] = 1'b0;
    #1;
    chk("reset_mid_outs", outs(0), 32'h0);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("reset_no_write", ram[0][12], 32'h1000_000C);
    issue(0, 0, 1'b0, 32'h30, 32'h0, 1'b0, 32'h1000_000C);
    step(2);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
